// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_t        : loader FSM state encoding (3 bits)
//   INSTR_W        : instruction word width in bits
//   BYTES_PER_WORD : stream bytes per instruction word
package imem_loader_pkg;

    localparam int INSTR_W        = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles stream bytes into a little-endian 32-bit instruction word.
//   clk, reset_n  : clock, asynchronous active-low reset
//   i_clear       : restart assembly at lane 0 (start of a new load)
//   i_byte_vld    : i_byte is consumed this cycle
//   i_byte        : stream byte
//   o_word        : assembled word (stable while the write is in progress)
//   o_last_lane   : next consumed byte completes the word
//   o_word_ready  : one-cycle flag, high the cycle after the 4th byte lands
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_clear,
    input  logic               i_byte_vld,
    input  logic [7:0]         i_byte,
    output logic [INSTR_W-1:0] o_word,
    output logic               o_last_lane,
    output logic               o_word_ready
);

    logic [1:0]         r_byte_idx;
    logic [INSTR_W-1:0] r_word;
    logic               r_word_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_byte_idx   <= 2'd0;
            r_word       <= '0;
            r_word_ready <= 1'b0;
        end else if (i_clear) begin
            r_byte_idx   <= 2'd0;
            r_word       <= '0;
            r_word_ready <= 1'b0;
        end else begin
            r_word_ready <= 1'b0;
            if (i_byte_vld) begin
                // Byte lane selected by index: first byte is least significant.
                r_word[{r_byte_idx, 3'b000} +: 8] <= i_byte;
                r_byte_idx   <= r_byte_idx + 2'd1;
                r_word_ready <= (r_byte_idx == 2'(BYTES_PER_WORD - 1));
            end
        end
    end

    assign o_word       = r_word;
    assign o_last_lane  = (r_byte_idx == 2'(BYTES_PER_WORD - 1));
    assign o_word_ready = r_word_ready;

endmodule

// File: rtl/imem_loader.sv
// Writer side of the instruction memory: receives a framed byte stream
// (LEN, 4*LEN little-endian payload bytes, CSUM) and writes the words to
// consecutive addresses from 0, holding the CPU in reset until a frame
// with a matching checksum has loaded.
//   clk, reset_n             : clock, asynchronous active-low reset
//   start                    : begin a load (honoured in IDLE/DONE/ERR)
//   in_valid/in_data/in_ready: byte stream handshake
//   mem_we/mem_addr/mem_wdata: instruction memory write port
//   cpu_hold                 : 1 = processor held in reset
//   done / error             : load result
//   words_loaded             : words written in the current/last load
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               error,
    output logic [ADDR_W:0]    words_loaded
);

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_words;
    logic [ADDR_W:0]     r_len;
    logic [7:0]          r_csum;
    logic                r_done;
    logic                r_error;
    logic                r_hold;

    logic                w_xfer;
    logic                w_start_ok;
    logic                w_byte_vld;
    logic                w_last_lane;
    logic                w_word_ready;
    logic [INSTR_W-1:0]  w_word;
    logic [ADDR_W:0]     w_words_inc;

    assign in_ready    = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_xfer      = in_valid && in_ready;
    // start is only looked at in the non-accepting states, so a start that
    // coincides with a transfer can never restart a load.
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign w_byte_vld  = w_xfer && (r_state == S_DATA);
    assign w_words_inc = r_words + (ADDR_W + 1)'(1);

    imem_word_packer u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_clear      (w_start_ok),
        .i_byte_vld   (w_byte_vld),
        .i_byte       (in_data),
        .o_word       (w_word),
        .o_last_lane  (w_last_lane),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_words <= '0;
            r_len   <= '0;
            r_csum  <= 8'd0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_hold  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (w_start_ok) begin
                        r_state <= S_LEN;
                        r_addr  <= '0;
                        r_words <= '0;
                        r_csum  <= 8'd0;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                        r_hold  <= 1'b1;
                    end
                end
                S_LEN: begin
                    if (w_xfer) begin
                        if ((in_data == 8'd0) || (in_data > DEPTH_B)) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end else begin
                            r_len   <= in_data[ADDR_W:0];
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_csum <= r_csum + in_data;
                        if (w_last_lane) r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_words <= w_words_inc;
                    if (w_words_inc == r_len) begin
                        // Keep the address on the last word so it never wraps.
                        r_state <= S_CSUM;
                    end else begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_state <= S_DATA;
                    end
                end
                S_CSUM: begin
                    if (w_xfer) begin
                        if (in_data == r_csum) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_hold  <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The packer's word-ready flag is high exactly during WRITE.
    assign mem_we       = w_word_ready;
    assign mem_addr     = r_addr;
    assign mem_wdata    = w_word;
    assign cpu_hold     = r_hold;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words;

endmodule
